// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared types, widths and reset values for the registered full adder.
package full_adder_pkg;
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] SUM_RST = '0;
    localparam logic COUT_RST = 1'b0;

    typedef struct packed {
        logic cout;
        logic sum;
    } bit_result_t;

    function automatic int result_w(int w);
        return w + 1;
    endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder, the ripple-chain building block.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic        a,
    input  logic        b,
    input  logic        cin,
    output bit_result_t res
);
    logic p;
    assign p = a ^ b;
    assign res.sum = p ^ cin;
    assign res.cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder_reg.sv
// full_adder_reg: registered WIDTH-bit ripple-carry adder with carry in/out.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_reg
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int RW = result_w(WIDTH);

    logic [RW-1:0]    c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bit_result_t r;
        full_adder_cell u_cell (.a(a[i]), .b(b[i]), .cin(c[i]), .res(r));
        assign s[i]   = r.sum;
        assign c[i+1] = r.cout;
    end

    // sum/cout only load on a valid beat so they hold between results
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= SUM_RST[WIDTH-1:0];
            cout      <= COUT_RST;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s;
                cout <= c[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (in_valid)
            ovf <= (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end
`endif
endmodule

// File: tb/tb_full_adder_reg.sv
// tb_full_adder_reg: directed checks of a 1-bit and an 8-bit registered adder.
module tb_full_adder_reg;
    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, c1;
    logic       ov1, s1, co1;
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic       ov8, co8;
    logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
    logic       of1, of8;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of1)
`endif
    );

    full_adder_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        tick();
        checks++;
        if ({ov1, co1, s1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_w1: got v/cout/sum=%b required 000", {ov1, co1, s1});
        end
        checks++;
        if ({ov8, co8, s8} !== 10'h000) begin
            errors++;
            $display("FAIL reset_w8: got v=%b cout=%b sum=%h required 0 0 00", ov8, co8, s8);
        end
`ifdef FULL_ADDER_OVF_EN
        checks++;
        if ({of1, of8} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ovf: got %b required 00", {of1, of8});
        end
`endif
        rst = 1'b0;
        tick();
        checks++;
        if ({ov1, co1, s1} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_w1: got v/cout/sum=%b required 111", {ov1, co1, s1});
        end
        checks++;
        if ({ov8, co8, s8} !== {2'b11, 8'hFF}) begin
            errors++;
            $display("FAIL reset_release_w8: got v=%b cout=%b sum=%h required 1 1 ff", ov8, co8, s8);
        end
        v1 = 1'b0; v8 = 1'b0;
        tick();
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] exp_tab [8];
        logic [2:0] vec;
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {a1, b1, c1} = vec;
            v1 = 1'b1;
            tick();
            checks++;
            if (ov1 !== 1'b1 || {co1, s1} !== exp_tab[i]) begin
                errors++;
                $display("FAIL exhaustive_%0d: got v=%b cout/sum=%b required v=1 %b", i, ov1, {co1, s1}, exp_tab[i]);
            end
        end
        v1 = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        tick();
        checks++;
        if ({ov1, co1, s1} !== 3'b101) begin
            errors++;
            $display("FAIL hold_load: got v/cout/sum=%b required 101", {ov1, co1, s1});
        end
        v1 = 1'b0; a1 = 1'b0; b1 = 1'bx; c1 = 1'bx;
        tick();
        tick();
        checks++;
        if ({ov1, co1, s1} !== 3'b001) begin
            errors++;
            $display("FAIL hold_idle: got v/cout/sum=%b required 001", {ov1, co1, s1});
        end
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    endtask

    task automatic test_wrap_w8();
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        tick();
        checks++;
        if ({ov8, co8, s8} !== {2'b11, 8'h00}) begin
            errors++;
            $display("FAIL wrap_max_plus_1: got v=%b cout=%b sum=%h required 1 1 00", ov8, co8, s8);
        end
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        checks++;
        if ({ov8, co8, s8} !== {2'b11, 8'hFF}) begin
            errors++;
            $display("FAIL wrap_all_ones: got v=%b cout=%b sum=%h required 1 1 ff", ov8, co8, s8);
        end
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        tick();
        checks++;
        if ({ov8, co8, s8} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL zero_sum: got v=%b cout=%b sum=%h required 1 0 00", ov8, co8, s8);
        end
        v8 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [4];
        logic [7:0] bv [4];
        logic       cv [4];
        logic [8:0] ev [4];
        av = '{8'h0C, 8'h80, 8'hA5, 8'h0F};
        bv = '{8'h22, 8'h80, 8'h5A, 8'h01};
        cv = '{1'b1, 1'b0, 1'b1, 1'b0};
        ev = '{9'h02F, 9'h100, 9'h100, 9'h010};
        for (int i = 0; i < 4; i++) begin
            v8 = 1'b1; a8 = av[i]; b8 = bv[i]; c8 = cv[i];
            tick();
            checks++;
            if (ov8 !== 1'b1 || {co8, s8} !== ev[i]) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b cout/sum=%h required v=1 %h", i, ov8, {co8, s8}, ev[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            logic [8:0] e;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            e = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
            tick();
            checks++;
            if (ov8 !== 1'b1 || {co8, s8} !== e) begin
                errors++;
                $display("FAIL stream_rand_%0d: got v=%b cout/sum=%h required v=1 %h", i, ov8, {co8, s8}, e);
            end
        end
        v8 = 1'b0;
        tick();
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got v=%b required 0", ov8);
        end
    endtask

    task automatic test_reset_mid_stream();
        v8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
        tick();
        rst = 1'b1; a8 = 8'h55; b8 = 8'h55; c8 = 1'b1;
        tick();
        checks++;
        if ({ov8, co8, s8} !== 10'h000) begin
            errors++;
            $display("FAIL mid_reset: got v=%b cout=%b sum=%h required 0 0 00", ov8, co8, s8);
        end
        rst = 1'b0; a8 = 8'h01; b8 = 8'h02; c8 = 1'b1;
        tick();
        checks++;
        if ({ov8, co8, s8} !== {2'b10, 8'h04}) begin
            errors++;
            $display("FAIL mid_reset_resume: got v=%b cout=%b sum=%h required 1 0 04", ov8, co8, s8);
        end
        v8 = 1'b0;
        tick();
    endtask

`ifdef FULL_ADDER_OVF_EN
    task automatic test_ovf();
        v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        tick();
        checks++;
        if ({co8, s8, of8} !== {1'b0, 8'h80, 1'b1}) begin
            errors++;
            $display("FAIL ovf_pos: got cout=%b sum=%h ovf=%b required 0 80 1", co8, s8, of8);
        end
        a8 = 8'h80; b8 = 8'hFF; c8 = 1'b0;
        tick();
        checks++;
        if ({co8, s8, of8} !== {1'b1, 8'h7F, 1'b1}) begin
            errors++;
            $display("FAIL ovf_neg: got cout=%b sum=%h ovf=%b required 1 7f 1", co8, s8, of8);
        end
        a8 = 8'h7E; b8 = 8'h00; c8 = 1'b1;
        tick();
        checks++;
        if ({s8, of8} !== {8'h7F, 1'b0}) begin
            errors++;
            $display("FAIL ovf_none: got sum=%h ovf=%b required 7f 0", s8, of8);
        end
        a8 = 8'h7F; b8 = 8'h00; c8 = 1'b1;
        tick();
        checks++;
        if ({s8, of8} !== {8'h80, 1'b1}) begin
            errors++;
            $display("FAIL ovf_cin: got sum=%h ovf=%b required 80 1", s8, of8);
        end
        v8 = 1'b0; a8 = 8'h00;
        tick();
        checks++;
        if (of8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: got %b required 1", of8);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        test_reset();
        test_exhaustive_w1();
        test_hold();
        test_wrap_w8();
        test_back_to_back();
        test_reset_mid_stream();
`ifdef FULL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
